// File: rtl/tick_gen_multi_pkg.sv
// Shared definitions for the multi-channel tick generator: channel-select width,
// mode encoding and the channel-select decode helper.
package tick_gen_multi_pkg;

    localparam int unsigned TG_CH_SEL_W = 4;

    typedef enum logic {
        TG_MODE_PERIODIC = 1'b0,
        TG_MODE_ONESHOT  = 1'b1
    } tg_mode_e;

    // True when a config select addresses channel idx; full-width compare so
    // out-of-range selects never alias onto a real channel.
    function automatic logic ch_sel_hit(input logic [TG_CH_SEL_W-1:0] sel,
                                        input int unsigned idx);
        return (32'(sel) == 32'(idx));
    endfunction

endpackage

// File: rtl/tick_gen_multi_chan.sv
// One tick channel: programmable divisor, optional one-shot, registered
// clock-enable pulse, 50% square wave and busy flag.
import tick_gen_multi_pkg::*;

module tick_chan #(
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(100000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_os,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic             BUSY_RST = (DIV_RST != CNT_ZERO);

    logic [CNT_W-1:0] div_r,   div_s;
    logic [CNT_W-1:0] count_r, count_s;
    tg_mode_e         os_r,    os_s;
    logic             spent_r, spent_s;
    logic             tick_r,  tick_s;
    logic             sq_r,    sq_s;
    logic             busy_r,  busy_s;
    logic             armed_s;
    logic             term_s;

    // Next-state logic; priority is config write, then clear, then counting.
    always_comb begin
        div_s   = div_r;
        os_s    = os_r;
        count_s = count_r;
        spent_s = spent_r;
        sq_s    = sq_r;
        tick_s  = 1'b0;
        armed_s = (div_r != CNT_ZERO) && !spent_r;
        term_s  = (count_r == (div_r - CNT_ONE));

        if (cfg_we) begin
            div_s   = cfg_div;
            os_s    = tg_mode_e'(cfg_os);
            count_s = CNT_ZERO;
            spent_s = 1'b0;
            if (clr) begin
                sq_s = 1'b0;
            end else begin
                sq_s = sq_r;
            end
        end else if (clr) begin
            count_s = CNT_ZERO;
            spent_s = 1'b0;
            sq_s    = 1'b0;
        end else if (en && armed_s) begin
            if (term_s) begin
                count_s = CNT_ZERO;
                tick_s  = 1'b1;
                sq_s    = ~sq_r;
                if (os_r == TG_MODE_ONESHOT) begin
                    spent_s = 1'b1;
                end else begin
                    spent_s = 1'b0;
                end
            end else begin
                count_s = count_r + CNT_ONE;
            end
        end else begin
            count_s = count_r;
        end

        busy_s = (div_s != CNT_ZERO) && !spent_s;
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= DIV_RST;
            os_r    <= TG_MODE_PERIODIC;
            count_r <= CNT_ZERO;
            spent_r <= 1'b0;
            tick_r  <= 1'b0;
            sq_r    <= 1'b0;
            busy_r  <= BUSY_RST;
        end else begin
            div_r   <= div_s;
            os_r    <= os_s;
            count_r <= count_s;
            spent_r <= spent_s;
            tick_r  <= tick_s;
            sq_r    <= sq_s;
            busy_r  <= busy_s;
        end
    end

    assign tick = tick_r;
    assign sq   = sq_r;
    assign busy = busy_r;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator top: decodes the config port into per-channel
// write strobes and instantiates one tick_chan per channel.
import tick_gen_multi_pkg::*;

module tick_gen_multi #(
    parameter int unsigned      N_CH    = 4,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(100000)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        en,
    input  logic [N_CH-1:0]        clr,
    input  logic                   cfg_we,
    input  logic [TG_CH_SEL_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]       cfg_div,
    input  logic                   cfg_os,
    output logic [N_CH-1:0]        tick,
    output logic [N_CH-1:0]        sq,
    output logic [N_CH-1:0]        busy
);

    logic [N_CH-1:0] ch_we_s;

    // Per-channel write strobe decode.
    always_comb begin
        ch_we_s = {N_CH{1'b0}};
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cfg_we && ch_sel_hit(cfg_ch, i)) begin
                ch_we_s[i] = 1'b1;
            end else begin
                ch_we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .clr     (clr[g]),
            .cfg_we  (ch_we_s[g]),
            .cfg_div (cfg_div),
            .cfg_os  (cfg_os),
            .tick    (tick[g]),
            .sq      (sq[g]),
            .busy    (busy[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed self-checking bench for tick_gen_multi (4 channels, DIV_RST=100000).
module tb_tick_gen_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic        cfg_os;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  busy;

    int checks   = 0;
    int failures = 0;
    int seen;

    tick_gen_multi #(
        .N_CH    (4),
        .CNT_W   (32),
        .DIV_RST (32'd100000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_os  (cfg_os),
        .tick    (tick),
        .sq      (sq),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [31:0] d, input logic os);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = d;
        cfg_os  = os;
        cyc();
        cfg_we  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 4'h0; clr = 4'h0;
        cfg_we = 1'b0; cfg_ch = 4'd0; cfg_div = 32'd0; cfg_os = 1'b0;
        cyc(); cyc();
        chk("rst_tick", {28'd0, tick}, 32'h0);
        chk("rst_sq",   {28'd0, sq},   32'h0);
        chk("rst_busy", {28'd0, busy}, 32'hF);
        rst = 1'b0;
        cyc();

        // ch0 D=4 periodic: ticks at 4,8,12, sq rises at 4, falls at 8
        cfg(4'd0, 32'd4, 1'b0);
        en = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("p4_tick_k%0d", k), {31'd0, tick[0]}, {31'd0, (k % 4 == 0)});
            chk($sformatf("p4_sq_k%0d", k),   {31'd0, sq[0]},   {31'd0, ((k / 4) % 2 == 1)});
        end

        // asynchronous reset mid-cycle with sq[0]=1
        #2 rst = 1'b1;
        #1;
        chk("arst_sq",   {28'd0, sq},   32'h0);
        chk("arst_tick", {28'd0, tick}, 32'h0);
        chk("arst_busy", {28'd0, busy}, 32'hF);
        cyc(); cyc();
        chk("arst_hold_sq", {28'd0, sq}, 32'h0);
        rst = 1'b0;
        en = 4'b0000;
        cyc();
        chk("arst_rel_tick", {28'd0, tick}, 32'h0);

        // ch1 D=1: tick stuck high, sq toggles; then D=0 disables
        cfg(4'd1, 32'd1, 1'b0);
        en = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("d1_tick_k%0d", k), {31'd0, tick[1]}, 32'd1);
            chk($sformatf("d1_sq_k%0d", k),   {31'd0, sq[1]},   {31'd0, (k % 2 == 1)});
        end
        cfg(4'd1, 32'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("d0_tick_k%0d", k), {31'd0, tick[1]}, 32'd0);
            chk($sformatf("d0_busy_k%0d", k), {31'd0, busy[1]}, 32'd0);
            chk($sformatf("d0_sq_k%0d", k),   {31'd0, sq[1]},   32'd1);
            cyc();
        end

        // ch2 D=5 one-shot
        en = 4'b0000;
        cfg(4'd2, 32'd5, 1'b1);
        en = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("os_tick_k%0d", k), {31'd0, tick[2]}, {31'd0, (k == 5)});
            chk($sformatf("os_busy_k%0d", k), {31'd0, busy[2]}, {31'd0, (k < 5)});
            chk($sformatf("os_sq_k%0d", k),   {31'd0, sq[2]},   {31'd0, (k >= 5)});
        end
        seen = 0;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            if (tick[2]) seen++;
        end
        chk("os_spent_ticks", seen, 32'd0);
        clr = 4'b0100;
        cyc();
        clr = 4'b0000;
        chk("os_clr_sq",   {31'd0, sq[2]},   32'd0);
        chk("os_clr_busy", {31'd0, busy[2]}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("os_rearm_tick_k%0d", k), {31'd0, tick[2]}, {31'd0, (k == 5)});
        end

        // ch0 D=4 rewritten to D=6 at count=3; ch1 (D=3) and ch3 (D=2) undisturbed
        en = 4'b0000;
        cfg(4'd0, 32'd4, 1'b0);
        cfg(4'd1, 32'd3, 1'b0);
        cfg(4'd3, 32'd2, 1'b0);
        en = 4'b1011;
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) begin
                cfg_we = 1'b1; cfg_ch = 4'd0; cfg_div = 32'd6; cfg_os = 1'b0;
            end
            cyc();
            cfg_we = 1'b0;
            chk($sformatf("wr_t0_k%0d", k), {31'd0, tick[0]}, {31'd0, (k == 10 || k == 16)});
            chk($sformatf("wr_sq0_k%0d", k), {31'd0, sq[0]}, {31'd0, (k >= 10 && k < 16)});
            chk($sformatf("wr_t1_k%0d", k), {31'd0, tick[1]}, {31'd0, (k % 3 == 0)});
            chk($sformatf("wr_t3_k%0d", k), {31'd0, tick[3]}, {31'd0, (k % 2 == 0)});
        end

        // ch0 D=4 with en low for 3 cycles at count=2
        en = 4'b0000;
        cfg(4'd0, 32'd4, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            en = (k >= 3 && k <= 5) ? 4'b0000 : 4'b0001;
            cyc();
            chk($sformatf("en_t0_k%0d", k), {31'd0, tick[0]}, {31'd0, (k == 7)});
            chk($sformatf("en_sq0_k%0d", k), {31'd0, sq[0]}, {31'd0, (k >= 7)});
        end

        // same-cycle clr + write on ch0: write D=3 applies and sq clears
        clr = 4'b0001;
        cfg(4'd0, 32'd3, 1'b0);
        clr = 4'b0000;
        chk("cw_sq0",   {31'd0, sq[0]},   32'd0);
        chk("cw_tick0", {31'd0, tick[0]}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k == 4) begin
                cfg_we = 1'b1; cfg_ch = 4'd12; cfg_div = 32'd1; cfg_os = 1'b0;
            end
            cyc();
            cfg_we = 1'b0;
            chk($sformatf("cw_t0_k%0d", k), {31'd0, tick[0]}, {31'd0, (k == 3 || k == 6)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
